// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline register.
//   CTRL_W          default control word width
//   CTRL_*          bit positions of the individual control fields
//   state_t         occupancy state of a stage (EMPTY / FULL / SKID)
package pipe_pkg;

  localparam int CTRL_W        = 9;

  localparam int CTRL_WREG     = 0;
  localparam int CTRL_M2REG    = 1;
  localparam int CTRL_WMEM     = 2;
  localparam int CTRL_ALUC_LSB = 3;
  localparam int CTRL_ALUC_MSB = 5;
  localparam int CTRL_ALUIMM   = 6;
  localparam int CTRL_SHIFT    = 7;
  localparam int CTRL_WZ       = 8;

  // EMPTY: no entry; FULL: main slot holds an entry; SKID: main and skid both hold one.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
//   clk   clock
//   clrn  asynchronous active-low clear
//   inc   count enable for this cycle
//   cnt   current count, sticks at all-ones
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer and synchronous flush. Empty or flushed slots appear downstream as
// bubbles with an all-zero control word.
//   clk, clrn                      clock, asynchronous active-low reset
//   flush                          kill held and incoming entries
//   in_valid / in_ready            upstream handshake (in_ready is registered)
//   in_ctrl, in_a, in_b, in_imm, in_rn    upstream entry
//   out_valid / out_ready          downstream handshake
//   out_ctrl, out_a, out_b, out_imm, out_rn  downstream entry
//   stall_cnt, bubble_cnt, flush_cnt   saturating performance counters,
//                                  present only when PIPE_STAGE_PERF_EN is defined
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int RN_W   = 5,
  parameter int CTRL_W = pipe_pkg::CTRL_W
`ifdef PIPE_STAGE_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [RN_W-1:0]   in_rn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [DATA_W-1:0] out_imm,
  output logic [RN_W-1:0]   out_rn
`ifdef PIPE_STAGE_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
`endif
);

  import pipe_pkg::*;

  localparam int ENTRY_W = CTRL_W + 3 * DATA_W + RN_W;

  state_t             state_reg, state_next;
  logic               in_ready_reg;
  logic [ENTRY_W-1:0] main_reg, main_next;
  logic [ENTRY_W-1:0] skid_reg, skid_next;
  logic [ENTRY_W-1:0] in_entry;
  logic [CTRL_W-1:0]  main_ctrl;
  logic               accept;
  logic               issue;

  assign in_entry = {in_ctrl, in_a, in_b, in_imm, in_rn};
  assign accept   = in_valid & in_ready_reg;
  assign issue    = out_valid & out_ready;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) begin
          state_next = ST_FULL;
          main_next  = in_entry;
        end
      end
      ST_FULL: begin
        if (accept && issue) begin
          main_next = in_entry;
        end else if (accept) begin
          state_next = ST_SKID;
          skid_next  = in_entry;
        end else if (issue) begin
          state_next = ST_EMPTY;
        end
      end
      ST_SKID: begin
        // in_ready is low here, so only the drain path exists.
        if (issue) begin
          state_next = ST_FULL;
          main_next  = skid_reg;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // Flush discards everything; slot contents become don't-care so they are simply held.
    if (flush) begin
      state_next = ST_EMPTY;
      main_next  = main_reg;
      skid_next  = skid_reg;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg    <= ST_EMPTY;
      in_ready_reg <= 1'b1;
      main_reg     <= '0;
      skid_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      // Registered copy of (state != SKID) keeps out_ready off the in_ready path.
      in_ready_reg <= (state_next != ST_SKID);
      main_reg     <= main_next;
      skid_reg     <= skid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != ST_EMPTY);
  assign {main_ctrl, out_a, out_b, out_imm, out_rn} = main_reg;
  assign out_ctrl  = out_valid ? main_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
  // Counter order: 0 = stall, 1 = bubble, 2 = flush.
  logic [2:0]       perf_inc;
  logic [CNT_W-1:0] perf_cnt [3];

  assign perf_inc = {flush, ~out_valid, out_valid & ~out_ready};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      pipe_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .clrn (clrn),
        .inc  (perf_inc[gi]),
        .cnt  (perf_cnt[gi])
      );
    end
  endgenerate

  assign stall_cnt  = perf_cnt[0];
  assign bubble_cnt = perf_cnt[1];
  assign flush_cnt  = perf_cnt[2];
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam int TB_CNT_W = 4;
  localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

  logic        clk;
  logic        clrn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_ctrl;
  logic [31:0] in_a, in_b, in_imm;
  logic [4:0]  in_rn;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_ctrl;
  logic [31:0] out_a, out_b, out_imm;
  logic [4:0]  out_rn;
`ifdef PIPE_STAGE_PERF_EN
  logic [TB_CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(
    .DATA_W (32),
    .RN_W   (5),
    .CTRL_W (9)
`ifdef PIPE_STAGE_PERF_EN
    , .CNT_W (TB_CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .clrn       (clrn),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_ctrl    (in_ctrl),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_imm     (in_imm),
    .in_rn      (in_rn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ctrl   (out_ctrl),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_imm    (out_imm),
    .out_rn     (out_rn)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the stage behaves as a FIFO of capacity two whose head is
  // visible downstream; a flush empties it.
  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  rn;
  } ent_t;

  ent_t q[$];
  int   m_stall  = 0;
  int   m_bubble = 0;
  int   m_flush  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] a, input logic [8:0] c,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_a      = a;
    in_b      = ~a;
    in_imm    = a ^ 32'h5A5A_0F0F;
    in_rn     = a[4:0] ^ 5'h15;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic model_reset();
    q.delete();
    m_stall  = 0;
    m_bubble = 0;
    m_flush  = 0;
  endtask

  // Check the visible state against the model, then advance one clock.
  task automatic cycle();
    ent_t head;
    ent_t e;
    bit   acc;
    bit   iss;
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      head = q[0];
      chk("out_ctrl", 64'(out_ctrl), 64'(head.ctrl));
      chk("out_a", 64'(out_a), 64'(head.a));
      chk("out_b", 64'(out_b), 64'(head.b));
      chk("out_imm", 64'(out_imm), 64'(head.imm));
      chk("out_rn", 64'(out_rn), 64'(head.rn));
    end else begin
      chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    end
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
    chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
    acc = in_valid && (q.size() < 2);
    iss = (q.size() > 0) && out_ready;
    e.ctrl = in_ctrl; e.a = in_a; e.b = in_b; e.imm = in_imm; e.rn = in_rn;
    if (q.size() > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
    if (q.size() == 0 && m_bubble < CNT_MAX) m_bubble++;
    if (flush && m_flush < CNT_MAX) m_flush++;
    @(posedge clk);
    #1;
    if (iss) begin
      $display("issue a=%08h ctrl=%03h rn=%0d", q[0].a, q[0].ctrl, q[0].rn);
      void'(q.pop_front());
    end
    if (acc) q.push_back(e);
    if (flush) q.delete();
  endtask

  task automatic async_reset();
    clrn = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_a", 64'(out_a), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    clrn = 1'b1;
  endtask

  initial begin
    bit          need_new;
    bit          acc_pred;
    bit          fl;
    logic [31:0] ra;
    logic [8:0]  rc;

    clrn = 1'b0;
    drive(0, 32'd0, 9'd0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("reset_out_a", 64'(out_a), 64'd0);
    chk("reset_out_rn", 64'(out_rn), 64'd0);
    model_reset();
    clrn = 1'b1;
    cycle();

    // Streaming at full rate.
    for (int i = 1; i <= 8; i++) begin
      drive(1, 32'(i), 9'(i * 3), 1, 0);
      cycle();
    end
    drive(0, 32'd0, 9'd0, 1, 0);
    repeat (2) cycle();

    // Back-pressure into the skid slot, then flush with a new entry offered.
    drive(1, 32'hA, 9'h011, 0, 0); cycle();
    drive(1, 32'hB, 9'h022, 0, 0); cycle();
    drive(0, 32'd0, 9'd0, 0, 0);   cycle();
    chk("skid_in_ready", {63'd0, in_ready}, 64'd0);
    drive(1, 32'hC, 9'h033, 0, 1); cycle();
    drive(0, 32'd0, 9'd0, 1, 0);   repeat (2) cycle();

    // Back-pressure and drain.
    drive(1, 32'hA, 9'h011, 0, 0); cycle();
    drive(1, 32'hB, 9'h022, 0, 0); cycle();
    drive(0, 32'd0, 9'd0, 1, 0);   repeat (4) cycle();

    // Bubble control: all-ones control word shows for one cycle only.
    drive(1, 32'h55, 9'h1FF, 0, 0); cycle();
    drive(0, 32'd0, 9'd0, 1, 0);    cycle();
    cycle();
    chk("bubble_ctrl_zero", 64'(out_ctrl), 64'd0);

    // Asynchronous reset while in SKID.
    drive(1, 32'hA, 9'h011, 0, 0); cycle();
    drive(1, 32'hB, 9'h022, 0, 0); cycle();
    drive(0, 32'd0, 9'd0, 0, 0);
    async_reset();
    cycle();

`ifdef PIPE_STAGE_PERF_EN
    drive(1, 32'h77, 9'h044, 0, 0); cycle();
    drive(0, 32'd0, 9'd0, 0, 0);
    repeat (20) cycle();
    chk("stall_saturated", 64'(stall_cnt), 64'd15);
    async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 32'd0, 9'd0, 1, 1); cycle();
      drive(0, 32'd0, 9'd0, 1, 0); cycle();
    end
    chk("flush_three", 64'(flush_cnt), 64'd3);
`endif

    // Randomized traffic; an offered entry is held until accepted or flushed.
    need_new = 1'b1;
    for (int k = 0; k < 400; k++) begin
      fl = ($urandom_range(0, 19) == 0);
      if (need_new) begin
        ra = $urandom;
        rc = 9'($urandom);
        drive(($urandom_range(0, 3) != 0), ra, rc, ($urandom_range(0, 9) < 7), fl);
      end else begin
        out_ready = ($urandom_range(0, 9) < 7);
        flush     = fl;
      end
      acc_pred = in_valid && (q.size() < 2);
      cycle();
      need_new = !in_valid || acc_pred || fl;
    end
    drive(0, 32'd0, 9'd0, 1, 0);
    repeat (3) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed-width inter-stage pipeline registers: one ID/EXE-class stage with a valid/ready handshake, a 2-entry skid buffer, and synchronous flush.
- Sits between any two pipeline stages (ID->EXE, EXE->MEM, ...).
- Allows back-pressure (stall) without combinational ready paths.
- Turns flushed or empty slots into bubbles whose control word is all-zero, so no register or memory write occurs.

Parameters:
DATA_W, 32, width of each operand payload (a, b, imm)
RN_W, 5, destination register number width
CTRL_W, 9, control word width (wreg, m2reg, wmem, aluc[2:0], aluimm, shift, wz at package-defined bit positions)
CNT_W, 16, width of the performance counters (used only with the optional feature)

Ports:
clk  in  1  clock, all state updates on posedge
clrn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry; registered
in_ctrl  in  CTRL_W  upstream control word
in_a  in  DATA_W  operand a
in_b  in  DATA_W  operand b
in_imm  in  DATA_W  immediate
in_rn  in  RN_W  destination register number
out_valid  out  1  downstream entry valid
out_ready  in  1  downstream accepts
out_ctrl  out  CTRL_W  control word; forced to 0 when out_valid=0
out_a, out_b, out_imm  out  DATA_W each  payload
out_rn  out  RN_W  destination register number

Behaviour:
- Interface: one clock, clk; reset clrn is asynchronous, active-low.
- Reset (clrn=0, asynchronous):
  - state=EMPTY; main and skid slots, all payload outputs and out_ctrl =0.
  - out_valid=0, in_ready=1 on the first edge after release.
- Transfers:
  - Accept: in_valid & in_ready.
  - Issue: out_valid & out_ready.
- Latency and throughput:
  - Latency 1 cycle from accept to out_valid.
  - Sustained throughput is 1 entry/cycle while out_ready=1.
- State machine (the main slot drives the outputs):
  - EMPTY: accept -> FULL, main<=in.
  - FULL, accept & issue -> FULL, main<=in.
  - FULL, accept & !issue -> SKID, skid<=in; main is held.
  - FULL, !accept & issue -> EMPTY.
  - FULL, neither -> FULL, hold.
  - SKID: in_ready=0. Issue -> FULL, main<=skid. Otherwise hold.
- in_ready = (state!=SKID), taken from a register only. There is no combinational path from out_ready.
- out_valid = (state!=EMPTY).
- Bubble: when out_valid=0, out_ctrl=0. out_a/out_b/out_imm/out_rn hold their last values (don't-care).
- Flush:
  - Highest priority: the next state is EMPTY regardless of accept/issue.
  - An entry presented the same cycle is dropped even though in_ready=1.
  - An issue that happens in the flush cycle still counts downstream; it is the downstream stage's job to ignore it.
- Upstream protocol: once in_valid is high it must hold stable until accepted. A flush releases upstream from this rule.
- Simultaneous flush and reset: reset wins.
- Payload is copied bit-exact; no width conversion.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt, bubble_cnt and flush_cnt, each CNT_W bits and saturating at all-ones.
  - stall_cnt increments each cycle out_valid & !out_ready.
  - bubble_cnt increments each cycle !out_valid.
  - flush_cnt increments each cycle flush=1.
  - All three clear on clrn=0.
- Undefined: the ports and logic are absent, and the datapath behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - CTRL_W and the control bit indices (CTRL_WREG, CTRL_M2REG, CTRL_WMEM, CTRL_ALUC_LSB/MSB, CTRL_ALUIMM, CTRL_SHIFT, CTRL_WZ).
  - A state enumeration localparam set: ST_EMPTY, ST_FULL, ST_SKID, 2-bit encoding.
- Sub-module pipe_sat_counter (CNT_W-wide saturating counter with inc and asynchronous clear) is instantiated three times under PIPE_STAGE_PERF_EN.

Test Plan:
- Reset: clrn=0 mid-stream with the stage in SKID -> immediately out_valid=0, out_ctrl=0, out_a=0. After release, in_ready=1.
- Streaming: out_ready=1, in_a=1..8 on consecutive cycles -> out_a=1..8 each appears exactly 1 cycle later, with no gaps and in_ready held at 1.
- Back-pressure: send a=0xA, 0xB with out_ready=0 -> state SKID, in_ready=0, out_a=0xA held. Raise out_ready -> 0xA then 0xB issue, in_ready returns to 1 the cycle after the first issue, no loss or duplication.
- Flush: in SKID holding 0xA and 0xB, assert flush with in_valid=1, a=0xC -> next cycle out_valid=0, out_ctrl=0; 0xA, 0xB and 0xC are never issued.
- Bubble control: in_ctrl=9'h1FF accepted, then out_ready=1 with no new input -> out_ctrl=0x1FF for one cycle, then 0 while out_valid=0.
- PIPE_STAGE_PERF_EN with CNT_W=4: hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 (saturated). Three flush pulses -> flush_cnt=3.
